// File: rtl/controller_pkg.sv
// Shared constants for the controller pad / logic-analyser front end:
// LA bit positions, pad channel indices and output-enable defaults.
package controller_pkg;

  // Logic-analyser bit map
  localparam int LA_OEB_BASE = 0;
  localparam int LA_VAL_BASE = 4;
  localparam int LA_CMPL_VAL = 7;
  localparam int LA_DRV_BASE = 8;

  // Pad channel indices, shared by the OEB and value-override fields
  localparam int CH_RESET    = 0;
  localparam int CH_LATCH    = 1;
  localparam int CH_TRIGGER  = 2;
  localparam int CH_COMPLETE = 3;

  // OEB values when the LA does not own them (reset/latch/trigger are inputs,
  // the completion pad is an output)
  localparam logic [3:0] OEB_LA_OFF_DEFAULT = 4'b0111;
  // Everything tri-stated while in reset
  localparam logic [3:0] OEB_RESET_VALUE    = 4'b1111;
  // Driver pads are enabled unless the LA says otherwise
  localparam logic       DRV_OEB_LA_OFF_DEFAULT = 1'b0;

endpackage

// File: rtl/input_conditioner.sv
// Conditions one asynchronous pad: registered LA override, N-stage
// synchroniser, programmable glitch filter and a rising-edge pulse.
module input_conditioner #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_BITS = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pad_in,
  input  logic                   la_own,
  input  logic                   la_val,
  input  logic [FILTER_BITS-1:0] filter_len,
  output logic                   level,
  output logic                   rise
);

  localparam logic [FILTER_BITS-1:0] FILTER_ONE = {{(FILTER_BITS-1){1'b0}}, 1'b1};

  logic                   own_q, own_d;
  logic                   val_q, val_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_BITS-1:0] cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   pad_mux;
  logic                   sync_out;

  // Override mux ahead of the synchroniser, then the disagreement counter
  always_comb begin
    own_d    = la_own;
    val_d    = la_val;
    pad_mux  = own_q ? val_q : pad_in;
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_mux};
    sync_out = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    level_d  = level_q;
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filter_len) begin
      level_d = sync_out;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + FILTER_ONE;
    end
    rise_d = level_d & ~level_q;
  end

  // State registers; the sync chain resets to the idle pad level
  always_ff @(posedge clock) begin
    if (reset) begin
      own_q   <= 1'b0;
      val_q   <= 1'b0;
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      own_q   <= own_d;
      val_q   <= val_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/controller_io_frontend.sv
// Controller pad / LA front end: conditions reset_n, latch and trigger pads,
// drives pad OEBs, stretches the update-complete pulse and keeps
// NUM_OF_BANKS gated registered copies of the backend bus.
module controller_io_frontend
  import controller_pkg::*;
#(
  parameter int NUM_OF_DRIVERS     = 10,
  parameter int NUM_OF_BANKS       = 2,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int SYNC_STAGES        = 2,
  parameter int FILTER_BITS        = 4,
  parameter int STRETCH_BITS       = 4
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [LA_DRV_BASE+NUM_OF_DRIVERS-1:0]      la_data_in,
  input  logic [LA_DRV_BASE+NUM_OF_DRIVERS-1:0]      la_oenb,
  input  logic                                       io_reset_n_in,
  input  logic                                       io_latch_data_in,
  input  logic                                       io_control_trigger_in,
  output logic                                       io_reset_n_oeb,
  output logic                                       io_latch_data_oeb,
  output logic                                       io_control_trigger_oeb,
  output logic [2*NUM_OF_DRIVERS-1:0]                io_driver_io_oeb,
  output logic                                       io_update_cycle_complete_out,
  output logic                                       io_update_cycle_complete_oeb,
  input  logic [FILTER_BITS-1:0]                     filter_len,
  input  logic [STRETCH_BITS-1:0]                    stretch_len,
  input  logic                                       update_cycle_complete,
  output logic                                       sys_reset_req,
  output logic                                       latch_level,
  output logic                                       latch_rise,
  output logic                                       trigger_level,
  output logic                                       trigger_rise,
  input  logic [MEM_ADDRESS_LENGTH-1:0]              int_row_select,
  input  logic [MEM_ADDRESS_LENGTH-1:0]              int_col_select,
  input  logic [15:0]                                int_data_out,
  input  logic [9:0]                                 int_mem_address,
  input  logic                                       int_output_active,
  input  logic [NUM_OF_BANKS-1:0]                    bank_enable,
  output logic [NUM_OF_BANKS*MEM_ADDRESS_LENGTH-1:0] bank_row_select,
  output logic [NUM_OF_BANKS*MEM_ADDRESS_LENGTH-1:0] bank_col_select,
  output logic [NUM_OF_BANKS*16-1:0]                 bank_data_out,
  output logic [NUM_OF_BANKS*10-1:0]                 bank_mem_address,
  output logic [NUM_OF_BANKS-1:0]                    bank_output_active,
  output logic [NUM_OF_DRIVERS-1:0]                  clock_out
);

  localparam logic [STRETCH_BITS-1:0] STRETCH_ONE = {{(STRETCH_BITS-1){1'b0}}, 1'b1};

  logic                        reset_n_level;
  logic                        reset_rise_unused;
  logic [3:0]                  pad_oeb_q, pad_oeb_d;
  logic [2*NUM_OF_DRIVERS-1:0] drv_oeb_q, drv_oeb_d;
  logic [STRETCH_BITS-1:0]     stretch_cnt_q, stretch_cnt_d;
  logic                        cmpl_out_q, cmpl_out_d;
  logic                        stretch_active;

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS), .RESET_LEVEL(1'b1)
  ) u_reset_cond (
    .clock(clock), .reset(reset), .pad_in(io_reset_n_in),
    .la_own(~la_oenb[LA_VAL_BASE+CH_RESET]), .la_val(la_data_in[LA_VAL_BASE+CH_RESET]),
    .filter_len(filter_len), .level(reset_n_level), .rise(reset_rise_unused)
  );

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS), .RESET_LEVEL(1'b0)
  ) u_latch_cond (
    .clock(clock), .reset(reset), .pad_in(io_latch_data_in),
    .la_own(~la_oenb[LA_VAL_BASE+CH_LATCH]), .la_val(la_data_in[LA_VAL_BASE+CH_LATCH]),
    .filter_len(filter_len), .level(latch_level), .rise(latch_rise)
  );

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS), .RESET_LEVEL(1'b0)
  ) u_trigger_cond (
    .clock(clock), .reset(reset), .pad_in(io_control_trigger_in),
    .la_own(~la_oenb[LA_VAL_BASE+CH_TRIGGER]), .la_val(la_data_in[LA_VAL_BASE+CH_TRIGGER]),
    .filter_len(filter_len), .level(trigger_level), .rise(trigger_rise)
  );

  // Filtered reset_n is low while reset is being requested
  assign sys_reset_req = ~reset_n_level;

  // OEB selection and completion stretcher with its post-stretch value override
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pad_oeb_d[i] = la_oenb[LA_OEB_BASE+i] ? OEB_LA_OFF_DEFAULT[i] : la_data_in[LA_OEB_BASE+i];
    end
    for (int d = 0; d < NUM_OF_DRIVERS; d++) begin
      drv_oeb_d[2*d +: 2] = la_oenb[LA_DRV_BASE+d] ? {2{DRV_OEB_LA_OFF_DEFAULT}}
                                                   : {2{la_data_in[LA_DRV_BASE+d]}};
    end
    if (update_cycle_complete) begin
      stretch_cnt_d = stretch_len;
    end else if (stretch_cnt_q != '0) begin
      stretch_cnt_d = stretch_cnt_q - STRETCH_ONE;
    end else begin
      stretch_cnt_d = stretch_cnt_q;
    end
    stretch_active = update_cycle_complete | (stretch_cnt_d != '0);
    cmpl_out_d     = la_oenb[LA_CMPL_VAL] ? stretch_active : la_data_in[LA_CMPL_VAL];
  end

  // Pad-side registers; pads come out of reset tri-stated
  always_ff @(posedge clock) begin
    if (reset) begin
      pad_oeb_q     <= OEB_RESET_VALUE;
      drv_oeb_q     <= '1;
      stretch_cnt_q <= '0;
      cmpl_out_q    <= 1'b0;
    end else begin
      pad_oeb_q     <= pad_oeb_d;
      drv_oeb_q     <= drv_oeb_d;
      stretch_cnt_q <= stretch_cnt_d;
      cmpl_out_q    <= cmpl_out_d;
    end
  end

  assign io_reset_n_oeb               = pad_oeb_q[CH_RESET];
  assign io_latch_data_oeb            = pad_oeb_q[CH_LATCH];
  assign io_control_trigger_oeb       = pad_oeb_q[CH_TRIGGER];
  assign io_update_cycle_complete_oeb = pad_oeb_q[CH_COMPLETE];
  assign io_driver_io_oeb             = drv_oeb_q;
  assign io_update_cycle_complete_out = cmpl_out_q;
  assign clock_out                    = {NUM_OF_DRIVERS{clock}};

  for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
    logic [MEM_ADDRESS_LENGTH-1:0] row_q, row_d;
    logic [MEM_ADDRESS_LENGTH-1:0] col_q, col_d;
    logic [15:0]                   data_q, data_d;
    logic [9:0]                    addr_q, addr_d;
    logic                          active_q, active_d;

    // Whole-bus capture when enabled; disabled banks hold fields and go inactive
    always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      data_d   = data_q;
      addr_d   = addr_q;
      active_d = 1'b0;
      if (bank_enable[b]) begin
        row_d    = int_row_select;
        col_d    = int_col_select;
        data_d   = int_data_out;
        addr_d   = int_mem_address;
        active_d = int_output_active;
      end
    end

    // Bank copy registers
    always_ff @(posedge clock) begin
      if (reset) begin
        row_q    <= '0;
        col_q    <= '0;
        data_q   <= '0;
        addr_q   <= '0;
        active_q <= 1'b0;
      end else begin
        row_q    <= row_d;
        col_q    <= col_d;
        data_q   <= data_d;
        addr_q   <= addr_d;
        active_q <= active_d;
      end
    end

    assign bank_row_select[b*MEM_ADDRESS_LENGTH +: MEM_ADDRESS_LENGTH] = row_q;
    assign bank_col_select[b*MEM_ADDRESS_LENGTH +: MEM_ADDRESS_LENGTH] = col_q;
    assign bank_data_out[b*16 +: 16]                                   = data_q;
    assign bank_mem_address[b*10 +: 10]                                = addr_q;
    assign bank_output_active[b]                                       = active_q;
  end

endmodule

// File: tb/tb_controller_io_frontend.sv
// Bench for controller_io_frontend: directed scenarios followed by random
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_controller_io_frontend;

  localparam int ND  = 10;
  localparam int NB  = 3;
  localparam int MAL = 6;
  localparam int SS  = 2;
  localparam int FB  = 4;
  localparam int SB  = 4;
  localparam int LAW = 8 + ND;
  localparam bit [3:0] OEB_DEFAULT = 4'b0111;

  logic              clock;
  logic              reset;
  logic [LAW-1:0]    la_data_in, la_oenb;
  logic              io_reset_n_in, io_latch_data_in, io_control_trigger_in;
  logic              io_reset_n_oeb, io_latch_data_oeb, io_control_trigger_oeb;
  logic [2*ND-1:0]   io_driver_io_oeb;
  logic              io_update_cycle_complete_out, io_update_cycle_complete_oeb;
  logic [FB-1:0]     filter_len;
  logic [SB-1:0]     stretch_len;
  logic              update_cycle_complete;
  logic              sys_reset_req, latch_level, latch_rise, trigger_level, trigger_rise;
  logic [MAL-1:0]    int_row_select, int_col_select;
  logic [15:0]       int_data_out;
  logic [9:0]        int_mem_address;
  logic              int_output_active;
  logic [NB-1:0]     bank_enable;
  logic [NB*MAL-1:0] bank_row_select, bank_col_select;
  logic [NB*16-1:0]  bank_data_out;
  logic [NB*10-1:0]  bank_mem_address;
  logic [NB-1:0]     bank_output_active;
  logic [ND-1:0]     clock_out;

  controller_io_frontend #(
    .NUM_OF_DRIVERS(ND), .NUM_OF_BANKS(NB), .MEM_ADDRESS_LENGTH(MAL),
    .SYNC_STAGES(SS), .FILTER_BITS(FB), .STRETCH_BITS(SB)
  ) dut (
    .clock(clock), .reset(reset), .la_data_in(la_data_in), .la_oenb(la_oenb),
    .io_reset_n_in(io_reset_n_in), .io_latch_data_in(io_latch_data_in),
    .io_control_trigger_in(io_control_trigger_in),
    .io_reset_n_oeb(io_reset_n_oeb), .io_latch_data_oeb(io_latch_data_oeb),
    .io_control_trigger_oeb(io_control_trigger_oeb), .io_driver_io_oeb(io_driver_io_oeb),
    .io_update_cycle_complete_out(io_update_cycle_complete_out),
    .io_update_cycle_complete_oeb(io_update_cycle_complete_oeb),
    .filter_len(filter_len), .stretch_len(stretch_len),
    .update_cycle_complete(update_cycle_complete), .sys_reset_req(sys_reset_req),
    .latch_level(latch_level), .latch_rise(latch_rise),
    .trigger_level(trigger_level), .trigger_rise(trigger_rise),
    .int_row_select(int_row_select), .int_col_select(int_col_select),
    .int_data_out(int_data_out), .int_mem_address(int_mem_address),
    .int_output_active(int_output_active), .bank_enable(bank_enable),
    .bank_row_select(bank_row_select), .bank_col_select(bank_col_select),
    .bank_data_out(bank_data_out), .bank_mem_address(bank_mem_address),
    .bank_output_active(bank_output_active), .clock_out(clock_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int cmpl_high    = 0;
  int latch_rises  = 0;
  int trig_rises   = 0;

  // Reference model state (channel 0 = reset_n, 1 = latch, 2 = trigger)
  bit             m_own[3];
  bit             m_val[3];
  logic [2:0]     m_syncq[$];
  bit             m_lvl[3];
  int             m_run[3];
  bit             m_rise[3];
  int             m_until;
  bit             m_cmpl;
  bit [3:0]       m_oeb;
  logic [2*ND-1:0] m_drv;
  logic [MAL-1:0] m_row[NB];
  logic [MAL-1:0] m_col[NB];
  logic [15:0]    m_data[NB];
  logic [9:0]     m_addr[NB];
  bit             m_act[NB];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs that the DUT just sampled
  task automatic modelEdge();
    logic [2:0] pads, mux, s_out;
    bit         old;
    cyc++;
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        m_own[c] = 0; m_val[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_rise[c] = 0;
      end
      m_syncq.delete();
      for (int i = 0; i < SS; i++) m_syncq.push_front(3'b001);
      m_until = -1;
      m_cmpl  = 0;
      m_oeb   = 4'hF;
      m_drv   = '1;
      for (int b = 0; b < NB; b++) begin
        m_row[b] = '0; m_col[b] = '0; m_data[b] = '0; m_addr[b] = '0; m_act[b] = 0;
      end
    end else begin
      pads = {io_control_trigger_in, io_latch_data_in, io_reset_n_in};
      for (int c = 0; c < 3; c++) mux[c] = m_own[c] ? m_val[c] : pads[c];
      s_out = m_syncq.pop_back();
      m_syncq.push_front(mux);
      for (int c = 0; c < 3; c++) begin
        old = m_lvl[c];
        if (s_out[c] == m_lvl[c]) m_run[c] = 0;
        else if (m_run[c] >= int'(filter_len)) begin
          m_lvl[c] = s_out[c];
          m_run[c] = 0;
        end else m_run[c]++;
        m_rise[c] = m_lvl[c] && !old;
        m_own[c]  = !la_oenb[4+c];
        m_val[c]  = la_data_in[4+c];
      end
      for (int i = 0; i < 4; i++) m_oeb[i] = la_oenb[i] ? OEB_DEFAULT[i] : la_data_in[i];
      for (int d = 0; d < ND; d++) begin
        m_drv[2*d]   = la_oenb[8+d] ? 1'b0 : la_data_in[8+d];
        m_drv[2*d+1] = la_oenb[8+d] ? 1'b0 : la_data_in[8+d];
      end
      if (update_cycle_complete)
        m_until = cyc + ((stretch_len == 0) ? 0 : int'(stretch_len) - 1);
      m_cmpl = !la_oenb[7] ? la_data_in[7] : (cyc <= m_until);
      for (int b = 0; b < NB; b++) begin
        if (bank_enable[b]) begin
          m_row[b] = int_row_select; m_col[b] = int_col_select;
          m_data[b] = int_data_out; m_addr[b] = int_mem_address;
          m_act[b] = int_output_active;
        end else m_act[b] = 0;
      end
    end
  endtask

  // Compare every registered output against the model
  task automatic checkAll();
    logic [NB*MAL-1:0] e_row, e_col;
    logic [NB*16-1:0]  e_data;
    logic [NB*10-1:0]  e_addr;
    logic [NB-1:0]     e_act;
    for (int b = 0; b < NB; b++) begin
      e_row[b*MAL +: MAL] = m_row[b]; e_col[b*MAL +: MAL] = m_col[b];
      e_data[b*16 +: 16] = m_data[b]; e_addr[b*10 +: 10] = m_addr[b];
      e_act[b] = m_act[b];
    end
    checkOutput("sys_reset_req", sys_reset_req, !m_lvl[0]);
    checkOutput("latch_level", latch_level, m_lvl[1]);
    checkOutput("latch_rise", latch_rise, m_rise[1]);
    checkOutput("trigger_level", trigger_level, m_lvl[2]);
    checkOutput("trigger_rise", trigger_rise, m_rise[2]);
    checkOutput("pad_oeb", {io_update_cycle_complete_oeb, io_control_trigger_oeb,
                            io_latch_data_oeb, io_reset_n_oeb}, m_oeb);
    checkOutput("driver_oeb", io_driver_io_oeb, m_drv);
    checkOutput("complete_out", io_update_cycle_complete_out, m_cmpl);
    checkOutput("bank_row", bank_row_select, e_row);
    checkOutput("bank_col", bank_col_select, e_col);
    checkOutput("bank_data", bank_data_out, e_data);
    checkOutput("bank_addr", bank_mem_address, e_addr);
    checkOutput("bank_active", bank_output_active, e_act);
  endtask

  // Run n clocks with the current inputs, checking one time unit after each edge
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      modelEdge();
      checkAll();
      if (io_update_cycle_complete_out === 1'b1) cmpl_high++;
      if (latch_rise === 1'b1) latch_rises++;
      if (trigger_rise === 1'b1) trig_rises++;
    end
  endtask

  // Directed scenarios then random traffic
  initial begin
    int first;
    int low_seen;
    reset = 1; la_oenb = '1; la_data_in = '0;
    io_reset_n_in = 1; io_latch_data_in = 0; io_control_trigger_in = 0;
    filter_len = 4'd3; stretch_len = 4'd4; update_cycle_complete = 0;
    int_row_select = '0; int_col_select = '0; int_data_out = '0; int_mem_address = '0;
    int_output_active = 0; bank_enable = '0;

    $display("[TB] reset state");
    applyStimulus(3);
    checkOutput("rst_pad_oebs", {io_reset_n_oeb, io_latch_data_oeb, io_control_trigger_oeb,
                                 io_update_cycle_complete_oeb}, 4'hF);
    checkOutput("rst_drv_oebs", io_driver_io_oeb, 20'hFFFFF);
    checkOutput("rst_sys_reset_req", sys_reset_req, 1'b1);
    checkOutput("rst_bank_row", bank_row_select, 18'h0);
    checkOutput("clock_out", clock_out, 10'h3FF);
    reset = 0;
    applyStimulus(1);
    checkOutput("rel_drv_oebs", io_driver_io_oeb, 20'h00000);
    checkOutput("rel_pad_oebs", {io_reset_n_oeb, io_latch_data_oeb, io_control_trigger_oeb,
                                 io_update_cycle_complete_oeb}, 4'b1110);
    applyStimulus(8);
    checkOutput("reset_req_released", sys_reset_req, 1'b0);

    $display("[TB] latch filter latency and glitch rejection");
    latch_rises = 0; first = 0;
    io_latch_data_in = 1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      if (first == 0 && latch_level === 1'b1) first = i;
    end
    checkOutput("latch_latency", first, SS + 3 + 1);
    checkOutput("latch_rise_once", latch_rises, 1);
    low_seen = 0;
    io_latch_data_in = 0;
    for (int i = 0; i < 3; i++) begin applyStimulus(1); low_seen += int'(latch_level !== 1'b1); end
    io_latch_data_in = 1;
    for (int i = 0; i < 10; i++) begin applyStimulus(1); low_seen += int'(latch_level !== 1'b1); end
    checkOutput("latch_glitch_reject", low_seen, 0);

    $display("[TB] completion stretcher");
    cmpl_high = 0;
    update_cycle_complete = 1; applyStimulus(1);
    update_cycle_complete = 0; applyStimulus(8);
    checkOutput("stretch_4", cmpl_high, 4);
    cmpl_high = 0;
    update_cycle_complete = 1; applyStimulus(1);
    update_cycle_complete = 0; applyStimulus(1);
    update_cycle_complete = 1; applyStimulus(1);
    update_cycle_complete = 0; applyStimulus(10);
    checkOutput("stretch_retrigger", cmpl_high, 6);
    stretch_len = 4'd0; cmpl_high = 0;
    update_cycle_complete = 1; applyStimulus(1);
    update_cycle_complete = 0; applyStimulus(5);
    checkOutput("stretch_zero", cmpl_high, 1);

    $display("[TB] bank gating");
    bank_enable = 3'b111; int_row_select = 6'h15; int_col_select = 6'h03;
    int_data_out = 16'h1234; int_mem_address = 10'h155; int_output_active = 1;
    applyStimulus(1);
    bank_enable = 3'b101; int_row_select = 6'h2A;
    applyStimulus(1);
    checkOutput("bank_101_row", bank_row_select, {6'h2A, 6'h15, 6'h2A});
    checkOutput("bank_101_active", bank_output_active, 3'b101);
    bank_enable = 3'b000; int_row_select = 6'h3F;
    applyStimulus(1);
    checkOutput("bank_off_active", bank_output_active, 3'b000);
    checkOutput("bank_off_hold", bank_row_select, {6'h2A, 6'h15, 6'h2A});

    $display("[TB] LA overrides");
    la_oenb[11] = 0; la_data_in[11] = 1;
    applyStimulus(1);
    checkOutput("drv3_override", io_driver_io_oeb, 20'h000C0);
    la_oenb[11] = 1; la_data_in[11] = 0;
    io_latch_data_in = 0;
    applyStimulus(8);
    checkOutput("latch_pad_low", latch_level, 1'b0);
    la_oenb[5] = 0; la_data_in[5] = 1;
    applyStimulus(10);
    checkOutput("latch_la_override", latch_level, 1'b1);
    la_oenb[5] = 1; la_data_in[5] = 0;
    applyStimulus(8);
    checkOutput("latch_la_released", latch_level, 1'b0);

    $display("[TB] reset during trigger filtering");
    filter_len = 4'd5;
    io_control_trigger_in = 1;
    applyStimulus(SS + 2);
    trig_rises = 0;
    reset = 1; applyStimulus(1);
    checkOutput("mid_reset_level", trigger_level, 1'b0);
    reset = 0; first = 0;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1);
      if (first == 0 && trigger_level === 1'b1) first = i;
    end
    checkOutput("post_reset_latency", first, SS + 5 + 1);
    checkOutput("post_reset_rise_once", trig_rises, 1);

    $display("[TB] random traffic");
    filter_len  = FB'($urandom_range(0, 4));
    stretch_len = SB'($urandom_range(0, 5));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) io_reset_n_in = ~io_reset_n_in;
      if ($urandom_range(0, 5) == 0) io_latch_data_in = ~io_latch_data_in;
      if ($urandom_range(0, 5) == 0) io_control_trigger_in = ~io_control_trigger_in;
      la_oenb     = ($urandom_range(0, 7) == 0) ? LAW'($urandom) : '1;
      la_data_in  = LAW'($urandom);
      update_cycle_complete = ($urandom_range(0, 5) == 0);
      bank_enable = NB'($urandom);
      int_row_select = MAL'($urandom); int_col_select = MAL'($urandom);
      int_data_out = 16'($urandom); int_mem_address = 10'($urandom);
      int_output_active = 1'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
